eq_mac_scheduler: RTL and testbench
===================================

Name: eq_mac_scheduler

Overview:
Time-multiplexed controller for the 3-band equalizer. It shares one 16x16 multiply-accumulate unit across three biquad bands and both stereo channels. Per-channel, per-band filter state is held internally and all 15 taps are sequenced for every new sample. Band coefficients are loaded through a shadow/commit configuration port, so gains can change without glitching a sample. Sits between the I2S receive path (audio_in, l_r_clk) and the I2S transmit path.

Parameters:
DATA_W, 16, audio sample width (signed)
COEF_W, 16, coefficient width, signed Q2.14
FRAC_BITS, 14, fractional bits of coefficients
ACC_W, 40, accumulator width (signed)
SYNC_STAGES, 2, l_r_clk synchronizer depth

Ports:
clk  in  1  high-speed system clock
reset  in  1  asynchronous, active-low reset
l_r_clk  in  1  I2S word select, asynchronous to clk; every edge = new sample; level after edge 0=left, 1=right
audio_in  in  DATA_W  sample for the channel selected by the edge; sampled at capture
cfg_we  in  1  write cfg_data to shadow coefficient cfg_addr
cfg_addr  in  4  band*5+tap; band 0=low, 1=mid, 2=high; tap order b0,b1,b2,a1,a2; 15 is ignored
cfg_data  in  COEF_W  coefficient value
cfg_commit  in  1  single-cycle request to copy shadow to active
cfg_pending  out  1  commit requested, not yet applied
overrun_clr  in  1  clears overrun_err
audio_out  out  DATA_W  summed equalizer output, registered
out_valid  out  1  one-cycle pulse when audio_out updates
out_channel  out  1  channel of current audio_out
busy  out  1  high from capture through the SUM cycle
overrun_err  out  1  sticky flag: edge arrived while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - audio_out=0, out_valid=0, out_channel=0, busy=0, cfg_pending=0, overrun_err=0.
  - All 24 state registers (x1,x2,y1,y2 per channel per band) = 0.
  - Shadow and active coefficients = package defaults: low b0=0x4000, all others 0 (unity pass-through).
  - FSM returns to IDLE. Reset mid-computation drops the sample; no out_valid is produced.
- Synchronizer: l_r_clk passes through SYNC_STAGES flops, then edge detect produces edge pulse in cycle T.
- FSM states and transitions:
  - IDLE -> CAPTURE on the edge pulse.
  - CAPTURE (T+1): latch audio_in as x0 and the channel; if cfg_pending, copy shadow to active and clear cfg_pending; busy=1.
  - MAC (T+2..T+16): 15 cycles, band-major, tap-minor. Operands are x0,x1,x2,y1,y2 of (channel,band). The accumulator clears at tap 0 of each band.
  - y[n] = b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2. Feedback coefficients are stored pre-negated, so every term is added.
  - Band result at tap a2 = (acc >>> FRAC_BITS), saturated to [-32768, 32767].
  - Writeback in that same cycle: x2<=x1, x1<=x0, y2<=y1, y1<=result; the result is also added to the 18-bit band sum.
  - SUM (T+17): saturate the band sum to 16 bits into audio_out; set out_channel; out_valid=1 for exactly this cycle; busy=0 after this cycle; -> IDLE.
- Latency: edge pulse at T to out_valid at T+17. Minimum edge spacing is 18 clk cycles.
- Edge pulse while busy: edge is dropped, overrun_err is set (sticky), and the current computation completes unaffected.
- overrun_clr and a new overrun in the same cycle: set wins.
- Config:
  - cfg_we writes shadow only; addr 15 is a no-op. Writes are accepted in any state.
  - cfg_commit sets cfg_pending; the copy happens only in CAPTURE, so one sample always uses one coefficient set.
  - cfg_we and cfg_commit in the same cycle: the write lands in shadow before the eventual copy.
  - Commit with no subsequent edge: cfg_pending stays high.
- Rounding: arithmetic shift truncation toward -inf; no rounding.
- Accumulator: no wrap for |coef| < 2.0 and 5 taps; saturation only at band and sum outputs.

Decomposition:
- Package eq_pkg:
  - width constants
  - tap index enum (B0,B1,B2,A1,A2)
  - band enum (LOW,MID,HIGH)
  - FSM state enum
  - default coefficient array
  - sat16 function
- Sub-module eq_mac_unit: registered signed multiply plus ACC_W accumulator with clear input and saturating Q2.14 output stage. The scheduler holds the FSM, counters, state bank and config registers.

Test Plan:
- Reset then L edge with audio_in=0x1000, default coefs -> out_valid exactly 17 cycles after edge pulse; audio_out=0x1000, out_channel=0.
- Write mid b0=0x2000 (0.5), commit, then R edge with 0x2000 -> next output 0x3000 (low 0x2000 + mid 0x1000); cfg_pending low after CAPTURE.
- Low band b0=0x4000, a1=0x2000 (y1*0.5); impulse 0x4000 on L followed by zeros -> L outputs 0x4000, 0x2000, 0x1000, 0x0800; R outputs stay 0 (channel state isolated).
- All three bands b0=0x7FFF, audio_in=0x7FFF -> audio_out saturates to 0x7FFF; with 0x8000 input -> 0x8000.
- Second l_r_clk edge 5 cycles after first -> overrun_err=1, exactly one out_valid; overrun_clr -> 0.
- Assert reset at MAC cycle 7 -> all outputs 0 immediately, no out_valid; next edge after release computes from zeroed state.

Source files
------------

// File: rtl/eq_pkg.sv
// eq_pkg: shared widths, enums, default coefficients and output saturation
package eq_pkg;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int FRAC_BITS = 14;
  localparam int ACC_W = 40;
  localparam int SUM_W = 18;
  localparam int SYNC_STAGES = 2;
  localparam int N_COEF = 16;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_e;
  typedef enum logic [1:0] {LOW, MID, HIGH} band_e;
  typedef enum logic [1:0] {IDLE, CAPTURE, MAC, SUM} state_e;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [DATA_W-1:0] sample_t;
  localparam coef_t DEFAULT_COEF [N_COEF] = '{0: 16'sh4000, default: 16'sh0000};
  function automatic sample_t sat16(input logic signed [ACC_W-1:0] v);
    return (v > 40'sd32767) ? 16'sh7fff : (v < -40'sd32768) ? 16'sh8000 : v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/eq_mac_unit.sv
// eq_mac_unit: signed coef*data accumulator with saturating Q2.14 output
module eq_mac_unit
  import eq_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    clr,
  input  coef_t   coef,
  input  sample_t data,
  output sample_t result
);
  localparam int PROD_W = COEF_W + DATA_W;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  assign prod = coef * data;
  assign acc_nxt = (clr ? '0 : acc) + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign result = sat16(acc_nxt >>> FRAC_BITS);
  // running sum of the current band; clr restarts it at tap b0
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (en) acc <= acc_nxt;
endmodule

// File: rtl/eq_mac_scheduler.sv
// eq_mac_scheduler: sequences one shared MAC over 3 biquad bands for both stereo channels
module eq_mac_scheduler
  import eq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              l_r_clk,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_pending,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] audio_out,
  output logic              out_valid,
  output logic              out_channel,
  output logic              busy,
  output logic              overrun_err
);
  state_e state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic lr_d, lr_edge, chan, band_end, last;
  logic [1:0] band;
  logic [2:0] tap;
  logic [3:0] cidx;
  sample_t x0, operand, result;
  sample_t x1 [2][3], x2 [2][3], y1 [2][3], y2 [2][3];
  coef_t shadow [N_COEF], active [N_COEF];
  logic signed [SUM_W-1:0] sum, sum_nxt;
  assign lr_edge = sync[SYNC_STAGES-1] ^ lr_d;
  assign busy = state != IDLE;
  assign band_end = state == MAC && tap == A2;
  assign last = band_end && band == HIGH;
  assign cidx = 4'(band) * 4'd5 + 4'(tap);
  assign sum_nxt = sum + SUM_W'(result);
  // operand select for the current tap and next-state logic
  always_comb begin
    operand = tap == B0 ? x0 : tap == B1 ? x1[chan][band] : tap == B2 ? x2[chan][band] :
              tap == A1 ? y1[chan][band] : y2[chan][band];
    state_nxt = state == IDLE ? (lr_edge ? CAPTURE : IDLE) :
                state == CAPTURE ? MAC :
                state == MAC ? (last ? SUM : MAC) : IDLE;
  end
  eq_mac_unit u_mac (
    .clk    (clk),
    .reset  (reset),
    .en     (state == MAC),
    .clr    (tap == B0),
    .coef   (active[cidx]),
    .data   (operand),
    .result (result)
  );
  // word-select synchronizer, edge history and state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      lr_d <= 1'b0;
      state <= IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], l_r_clk};
      lr_d <= sync[SYNC_STAGES-1];
      state <= state_nxt;
    end
  // sample capture, tap/band counters and per-channel filter state writeback
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      band <= '0;
      tap <= '0;
      x0 <= '0;
      chan <= 1'b0;
      sum <= '0;
      for (int c = 0; c < 2; c++)
        for (int b = 0; b < 3; b++) begin
          x1[c][b] <= '0;
          x2[c][b] <= '0;
          y1[c][b] <= '0;
          y2[c][b] <= '0;
        end
    end else if (state == CAPTURE) begin
      band <= '0;
      tap <= '0;
      x0 <= audio_in;
      chan <= lr_d;
      sum <= '0;
    end else if (state == MAC) begin
      tap <= band_end ? '0 : tap + 3'd1;
      band <= band_end ? band + 2'd1 : band;
      if (band_end) begin
        x2[chan][band] <= x1[chan][band];
        x1[chan][band] <= x0;
        y2[chan][band] <= y1[chan][band];
        y1[chan][band] <= result;
        sum <= sum_nxt;
      end
    end
  // output register loads on the final tap so it is visible during SUM
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      audio_out <= '0;
      out_valid <= 1'b0;
      out_channel <= 1'b0;
    end else begin
      out_valid <= last;
      if (last) begin
        audio_out <= sat16(ACC_W'(sum_nxt));
        out_channel <= chan;
      end
    end
  // shadow writes anytime; active set swaps only at capture so a sample never mixes sets
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shadow <= DEFAULT_COEF;
      active <= DEFAULT_COEF;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr != 4'd15) shadow[cfg_addr] <= cfg_data;
      if (state == CAPTURE && cfg_pending) active <= shadow;
      cfg_pending <= cfg_commit || (cfg_pending && state != CAPTURE);
    end
  // sticky overrun; a new overrun beats a simultaneous clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) overrun_err <= 1'b0;
    else overrun_err <= (lr_edge && busy) ? 1'b1 : overrun_clr ? 1'b0 : overrun_err;
endmodule

// File: tb/tb_eq_mac_scheduler.sv
// tb_eq_mac_scheduler: directed and random checks against a behavioural equalizer model
module tb_eq_mac_scheduler;
  logic clk = 0, reset = 0, l_r_clk = 0, cfg_we = 0, cfg_commit = 0, overrun_clr = 0;
  logic [15:0] audio_in = 0, cfg_data = 0;
  logic [3:0] cfg_addr = 0;
  logic cfg_pending, out_valid, out_channel, busy, overrun_err;
  logic [15:0] audio_out;
  int errs = 0, checks = 0;
  logic lr = 0;
  int m_shadow [16], m_active [16];
  bit m_pending;
  int mx1 [2][3], mx2 [2][3], my1 [2][3], my2 [2][3];

  eq_mac_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .l_r_clk     (l_r_clk),
    .audio_in    (audio_in),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_pending (cfg_pending),
    .overrun_clr (overrun_clr),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .out_channel (out_channel),
    .busy        (busy),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = (i == 0) ? 16384 : 0;
      m_active[i] = m_shadow[i];
    end
    m_pending = 0;
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < 3; b++) begin
        mx1[c][b] = 0; mx2[c][b] = 0; my1[c][b] = 0; my2[c][b] = 0;
      end
  endtask

  task automatic model_sample(input int ch, input int x, output int y);
    longint acc, total;
    int yb;
    total = 0;
    if (m_pending) begin
      m_active = m_shadow;
      m_pending = 0;
    end
    for (int b = 0; b < 3; b++) begin
      acc = longint'(m_active[b*5]) * x + longint'(m_active[b*5+1]) * mx1[ch][b]
          + longint'(m_active[b*5+2]) * mx2[ch][b] + longint'(m_active[b*5+3]) * my1[ch][b]
          + longint'(m_active[b*5+4]) * my2[ch][b];
      yb = sat(acc >>> 14);
      mx2[ch][b] = mx1[ch][b]; mx1[ch][b] = x;
      my2[ch][b] = my1[ch][b]; my1[ch][b] = yb;
      total += yb;
    end
    y = sat(total);
  endtask

  task automatic cfg(input logic [3:0] a, input logic [15:0] d, input logic we, input logic cm);
    @(posedge clk); #1;
    cfg_we = we; cfg_addr = a; cfg_data = d; cfg_commit = cm;
    @(posedge clk); #1;
    cfg_we = 0; cfg_commit = 0;
    if (we && a != 4'd15) m_shadow[a] = int'($signed(d));
    if (cm) m_pending = 1;
  endtask

  task automatic sample(input logic [15:0] x);
    int exp, n, cnt, lat;
    logic [15:0] got;
    logic gch, bz;
    lr = ~lr;
    model_sample(int'(lr), int'($signed(x)), exp);
    @(posedge clk); #1;
    audio_in = x; l_r_clk = lr;
    n = 0; cnt = 0; lat = 0; got = 0; gch = 0; bz = 0;
    repeat (25) begin
      @(negedge clk);
      n++;
      if (n == 6) bz = busy;
      if (out_valid) begin
        cnt++;
        if (cnt == 1) begin lat = n; got = audio_out; gch = out_channel; end
      end
    end
    chk("latency", lat, 20);
    chk("valid_count", cnt, 1);
    chk("audio_out", got, exp & 'hffff);
    chk("out_channel", gch, lr);
    chk("busy_mac", bz, 1);
  endtask

  task automatic do_reset();
    reset = 0; l_r_clk = 0; lr = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    model_reset();
  endtask

  initial begin
    int exp, cnt;
    logic [15:0] got;
    logic gch;
    model_reset();
    #12;
    chk("rst_audio_out", audio_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_channel", out_channel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_pending", cfg_pending, 0);
    chk("rst_overrun", overrun_err, 0);
    @(posedge clk); #1 reset = 1;
    // unity pass-through on default coefficients
    sample(16'h0000);
    sample(16'h1000);
    // mid band 0.5, committed, applied at the next capture
    cfg(4'd5, 16'h2000, 1, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_held", cfg_pending, 1);
    sample(16'h2000);
    chk("pending_cleared", cfg_pending, 0);
    // low band feedback a1=0.5 impulse response, right channel stays silent
    do_reset();
    cfg(4'd3, 16'h2000, 1, 1);
    sample(16'h0000);
    for (int i = 0; i < 4; i++) begin
      sample(i == 0 ? 16'h4000 : 16'h0000);
      sample(16'h0000);
    end
    // saturation with all bands near 2.0; address 15 writes are ignored
    cfg(4'd3, 16'h0000, 1, 0);
    cfg(4'd0, 16'h7fff, 1, 0);
    cfg(4'd5, 16'h7fff, 1, 0);
    cfg(4'd15, 16'h1234, 1, 0);
    cfg(4'd10, 16'h7fff, 1, 1);
    sample(16'h7fff);
    sample(16'h8000);
    // second edge while busy is dropped and flagged
    chk("overrun_pre", overrun_err, 0);
    lr = ~lr;
    model_sample(int'(lr), int'($signed(16'h0123)), exp);
    @(posedge clk); #1;
    audio_in = 16'h0123; l_r_clk = lr;
    repeat (5) @(posedge clk);
    #1 l_r_clk = ~lr;
    cnt = 0; got = 0; gch = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        got = audio_out; gch = out_channel;
      end
    end
    chk("overrun_set", overrun_err, 1);
    chk("overrun_valid_count", cnt, 1);
    chk("overrun_audio_out", got, exp & 'hffff);
    chk("overrun_channel", gch, lr);
    lr = ~lr;
    @(posedge clk); #1 overrun_clr = 1;
    @(posedge clk); #1 overrun_clr = 0;
    @(negedge clk);
    chk("overrun_cleared", overrun_err, 0);
    sample(16'h0100);
    // reset in the middle of MAC drops the sample
    lr = ~lr;
    @(posedge clk); #1;
    audio_in = 16'h5555; l_r_clk = lr;
    repeat (11) @(posedge clk);
    #2 reset = 0; l_r_clk = 0; lr = 0;
    #1;
    chk("midrst_audio_out", audio_out, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_channel", out_channel, 0);
    chk("midrst_overrun", overrun_err, 0);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);
    @(posedge clk); #1 reset = 1;
    model_reset();
    sample(16'h1234);
    sample(16'hfedc);
    // random coefficients, commits and samples
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 1)
        cfg(4'($urandom_range(0, 15)), 16'($urandom), 1, 1'($urandom_range(0, 1)));
      sample(16'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
